// File: rtl/ripple_serial_alu_if.sv
// Request/response bundle for the serial carry-chain ALU.
// The requester drives operands and START; the ALU returns status and result.
interface ripple_serial_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       opsel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             flag;

  modport master (
    output start, opsel, a, b, ci,
    input  busy, done, s, co, flag
  );

  modport slave (
    input  start, opsel, a, b, ci,
    output busy, done, s, co, flag
  );
endinterface

// File: rtl/ripple_serial_alu.sv
// Serial ALU: one 2-bit carry-chain slice per clock, carry held in a register.
// state | meaning:  IDLE - waiting, results held | RUN - slice steps | FIN - DONE pulse, results held
module ripple_serial_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               lsr_i,
  ripple_serial_alu_if.slave bus
);

  localparam int N  = WIDTH / 2;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_GE  = 2'b10;
  localparam logic [1:0] OP_NE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bw_q, bw_d;
  logic             carry_q, carry_d;
  logic             ne_q, ne_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             flag_q, flag_d;

  logic [1:0]       a_pair, b_pair;
  logic [2:0]       sum;
  logic             last_step;

  always_ff @(posedge clk_i) begin
    if (lsr_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      bw_q    <= '0;
      carry_q <= 1'b0;
      ne_q    <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
      a_q     <= a_d;
      bw_q    <= bw_d;
      carry_q <= carry_d;
      ne_q    <= ne_d;
      s_q     <= s_d;
      co_q    <= co_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    op_d      = op_q;
    a_d       = a_q;
    bw_d      = bw_q;
    carry_d   = carry_q;
    ne_d      = ne_q;
    s_d       = s_q;
    co_d      = co_q;
    flag_d    = flag_q;
    a_pair    = 2'b00;
    b_pair    = 2'b00;
    sum       = 3'b000;
    last_step = (step_q == SW'(N - 1));

    for (int k = 0; k < N; k++) begin
      if (step_q == SW'(k)) begin
        a_pair = a_q[2*k +: 2];
        b_pair = bw_q[2*k +: 2];
      end
    end

    case (state_q)
      RUN: begin
        sum     = {1'b0, a_pair} + {1'b0, b_pair} + {2'b00, carry_q};
        carry_d = sum[2];
        ne_d    = ne_q | (|(a_pair ^ b_pair));
        for (int k = 0; k < N; k++) begin
          if (step_q == SW'(k)) begin
            s_d[2*k +: 2] = (op_q == OP_ADD || op_q == OP_SUB) ? sum[1:0] : 2'b00;
          end
        end
        if (last_step) begin
          state_d = FIN;
          co_d    = (op_q == OP_NE) ? 1'b0 : sum[2];
          case (op_q)
            OP_GE:   flag_d = sum[2];
            OP_NE:   flag_d = ne_d;
            default: flag_d = (s_d == '0);
          endcase
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: begin
        // IDLE and FIN both accept; FIN falls back to IDLE so DONE is one cycle
        if (state_q == FIN) state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          step_d  = '0;
          op_d    = bus.opsel;
          a_d     = bus.a;
          bw_d    = (bus.opsel == OP_SUB || bus.opsel == OP_GE) ? ~bus.b : bus.b;
          case (bus.opsel)
            OP_GE:   carry_d = 1'b1;
            OP_NE:   carry_d = 1'b0;
            default: carry_d = bus.ci;
          endcase
          ne_d    = 1'b0;
          s_d     = '0;
          co_d    = 1'b0;
          flag_d  = 1'b0;
        end
      end
    endcase
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == FIN);
  assign bus.s    = s_q;
  assign bus.co   = co_q;
  assign bus.flag = flag_q;

endmodule

// File: tb/tb_ripple_serial_alu.sv
// Directed bench for ripple_serial_alu: a scoreboard queue of hand-computed
// results is drained by a monitor whenever DONE is seen.
module tb_ripple_serial_alu;

  logic clk_i = 1'b0;
  logic lsr_i;

  ripple_serial_alu_if #(.WIDTH(8)) bus ();

  ripple_serial_alu #(.WIDTH(8)) dut (
    .clk_i (clk_i),
    .lsr_i (lsr_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       flag;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every DONE pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_done: got S=%h CO=%b FLAG=%b expected no DONE",
                 bus.s, bus.co, bus.flag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, {23'd0, bus.s, bus.co, bus.flag}, {23'd0, e.s, e.co, e.flag});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es, input logic eco,
                       input logic eflag, input string nm);
    bus.opsel = op;
    bus.a     = a;
    bus.b     = b;
    bus.ci    = ci;
    bus.start = 1'b1;
    sb_q.push_back('{es, eco, eflag, nm});
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.ci    = ~ci;
    bus.opsel = ~op;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (bus.done !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    if (bus.done !== 1'b1) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic [7:0] es, input logic eco,
                        input logic eflag, input string nm);
    issue(op, a, b, ci, es, eco, eflag, nm);
    wait_done(nm);
    tick();
  endtask

  initial begin
    bit saw_done;
    bus.start = 1'b0;
    bus.opsel = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.ci    = 1'b0;
    lsr_i     = 1'b1;
    tick();
    tick();
    lsr_i = 1'b0;
    check("reset_state", {27'd0, bus.busy, bus.done, bus.co, bus.flag, (bus.s == 8'h00)},
          32'd1);

    // ADD with explicit cycle-by-cycle latency checks
    issue(2'b00, 8'hB7, 8'h5A, 1'b0, 8'h11, 1'b1, 1'b0, "add_b7_5a");
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("add_busy_cycle%0d", c), {30'd0, bus.busy, bus.done}, 32'd2);
      tick();
    end
    check("add_done_cycle5", {30'd0, bus.busy, bus.done}, 32'd1);
    tick();
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("result_hold", {23'd0, bus.s, bus.co, bus.flag}, {23'd0, 8'h11, 1'b1, 1'b0});

    run_op(2'b01, 8'h40, 8'h41, 1'b1, 8'hFF, 1'b0, 1'b0, "sub_40_41");
    run_op(2'b01, 8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b1, "sub_33_33");
    run_op(2'b00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, "add_ff_00_ci");
    run_op(2'b10, 8'h80, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b1, "ge_80_7f");
    run_op(2'b10, 8'h7F, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, "ge_7f_80");
    run_op(2'b10, 8'h5C, 8'h5C, 1'b0, 8'h00, 1'b1, 1'b1, "ge_5c_5c");
    run_op(2'b11, 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, "ne_a5_a5");
    run_op(2'b11, 8'hA5, 8'hA4, 1'b1, 8'h00, 1'b0, 1'b1, "ne_a5_a4");

    // START while busy must be ignored
    issue(2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "add_ignore_start");
    tick();
    bus.opsel = 2'b01;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("add_ignore_start");

    // back-to-back: START held in the DONE cycle
    bus.opsel = 2'b00;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.ci    = 1'b0;
    bus.start = 1'b1;
    sb_q.push_back('{8'h30, 1'b0, 1'b0, "add_back_to_back"});
    tick();
    bus.start = 1'b0;
    check("b2b_accept", {30'd0, bus.busy, bus.done}, 32'd2);
    wait_done("add_back_to_back");
    tick();

    // reset mid-RUN aborts with no DONE
    bus.opsel = 2'b00;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    bus.ci    = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    lsr_i = 1'b1;
    tick();
    lsr_i = 1'b0;
    check("abort_cleared", {22'd0, bus.busy, bus.done, bus.s, bus.co, bus.flag}, 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    // LSR wins over START in the same cycle
    bus.start = 1'b1;
    lsr_i     = 1'b1;
    tick();
    bus.start = 1'b0;
    lsr_i     = 1'b0;
    check("lsr_over_start", {31'd0, bus.busy}, 32'd0);
    tick();
    check("lsr_over_start_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    repeat (3) tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ripple_serial_alu.md
Name: ripple_serial_alu

Overview:
- Time-multiplexed counterpart of the combinational carry-chain slice.
- Instead of rippling carry through WIDTH/2 two-bit slices in one cycle, it processes one 2-bit slice per clock and holds the carry in a register between steps.
- Supports ADD, SUB, A_GE_B and A_NE_B, the same operation set as the ALU2 slice modes, behind a START/BUSY/DONE handshake.
- Used where carry-chain resources are scarce and multi-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width. Must be even and >= 2. N = WIDTH/2 is the number of slice steps.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- LSR  input  1  synchronous active-high reset.
- START  input  1  request a new operation; sampled only when not BUSY.
- OPSEL  input  2  operation select: 00 ADD, 01 SUB, 10 A_GE_B, 11 A_NE_B.
- A  input  WIDTH  operand A, captured when START is accepted.
- B  input  WIDTH  operand B, captured when START is accepted.
- CI  input  1  carry-in for ADD/SUB, captured when START is accepted.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse when results become valid.
- S  output  WIDTH  sum/difference result.
- CO  output  1  final carry (ADD/SUB/A_GE_B).
- FLAG  output  1  ADD/SUB: result==0; A_GE_B: A>=B unsigned; A_NE_B: A!=B.

Behaviour:
- States: IDLE, RUN, FIN.
- Reset (LSR=1 at a rising edge):
  - state=IDLE; BUSY=0, DONE=0, S=0, CO=0, FLAG=0; step counter=0; carry register=0.
  - LSR has priority over everything, including START in the same cycle.
  - Reset during RUN aborts the operation: no DONE, outputs cleared.
- Accept rule: START=1 while state is IDLE or FIN.
  - Latch A, B, OPSEL, CI; counter=0; state=RUN; BUSY=1 from the next cycle.
  - Initial carry: ADD=CI; SUB=CI (CI=1 gives plain A-B); A_GE_B=1; A_NE_B=0.
  - Latch the working operand B' = ~B for SUB/A_GE_B, B otherwise.
- RUN, step k (k=0..N-1), one step per clock:
  - Two-bit add of A[2k+1:2k] + B'[2k+1:2k] + carry; write the sum into S[2k+1:2k]; update the carry.
  - A_NE_B: accumulate an OR of (A XOR B) over the pair into an internal ne register; S bits are written 0.
  - A_GE_B: S bits are written 0; only the carry is kept.
- After the step with k=N-1: state=FIN, BUSY=0, DONE=1 for exactly one cycle.
  - CO = final carry; CO=0 for A_NE_B.
  - FLAG per mode: (S==0) for ADD/SUB, carry for A_GE_B, ne for A_NE_B.
- Latency: START sampled at edge 0; BUSY high in cycles 1..N; DONE high in cycle N+1. Total N+1 cycles from request to DONE.
- Hold: S, CO and FLAG stay stable from DONE until the next accepted START, then clear to 0 at acceptance.
- START while BUSY is ignored (not queued). Operand changes after acceptance have no effect.
- Back-to-back: START in the DONE cycle is accepted. DONE drops and BUSY rises the next cycle.
- Arithmetic is modulo 2^WIDTH. For SUB, CO=1 means no borrow (A+~B+CI >= 2^WIDTH).
- S is updated incrementally during RUN, but is only architecturally valid while in FIN/IDLE after DONE.

Test Plan:
- WIDTH=8 ADD: A=B7, B=5A, CI=0 -> DONE in cycle 5, S=11, CO=1, FLAG=0; BUSY high in cycles 1-4 only.
- SUB: A=40, B=41, CI=1 -> S=FF, CO=0, FLAG=0. SUB: A=33, B=33, CI=1 -> S=00, CO=1, FLAG=1.
- A_GE_B: A=80, B=7F -> FLAG=1, CO=1, S=00. A=7F, B=80 -> FLAG=0, CO=0. A=B=5C -> FLAG=1.
- A_NE_B: A=B=A5 -> FLAG=0. A=A5, B=A4 -> FLAG=1, CO=0.
- Handshake:
  - ADD 01+01 started; START pulsed in cycle 2 with A=FF, B=FF -> ignored, result S=02.
  - START held high in the DONE cycle with A=10, B=20 -> accepted; DONE N+1 cycles later with S=30.
- Reset: START ADD FF+01, LSR=1 in cycle 2 -> cycle 3 BUSY=0, S=00, CO=0; no DONE pulse ever. LSR and START in the same cycle -> stays IDLE.
